apb_addr_decode_interconnect: RTL and testbench
===============================================

Name: apb_addr_decode_interconnect

Overview:
- N-master, M-slave APB interconnect that selects the target slave by address decode, not by a master-supplied slave ID.
- Arbitrates among requesting masters using fixed-priority or round-robin arbitration, selected by parameter.
- Forwards one transfer at a time to the decoded slave and routes PREADY, PRDATA and PSLVERR back to the granted master only.
- Answers unmapped addresses itself with an error. Sits between the APB_MASTER and APB_SLAVE arrays in the system top level.

Parameters:
- ADDR_WIDTH, 32, address width of every port.
- DATA_WIDTH, 32, data width of every port.
- NO_OF_MASTERS, 2, number of master ports, 1..16.
- NO_OF_SLAVES, 4, number of slave ports, 1..16.
- ARBITRATION_TYPE, 0, 0 = fixed priority (lowest index wins), 1 = round robin.
- SLAVE_BASEADDR[NO_OF_SLAVES], '{0,'h1000,'h2000,'h3000}, first address of each slave region.
- SLAVE_SIZE[NO_OF_SLAVES], '{'h1000,...}, region size in address units; a region covers base <= addr < base+size.
- TIMEOUT_CYCLES, 16, ACCESS-cycle limit; used only with the optional feature.

Ports:
- I_PCLK  in  1  clock.
- I_PRESETN  in  1  asynchronous active-low reset.
- IFM_PSEL  in  [NO_OF_MASTERS]  per-master transfer request.
- IFM_PENABLE  in  [NO_OF_MASTERS]  per-master enable; ignored for routing.
- IFM_PWRITE  in  [NO_OF_MASTERS]  per-master direction.
- IFM_PADDR  in  [NO_OF_MASTERS][ADDR_WIDTH]  per-master address.
- IFM_PWDATA  in  [NO_OF_MASTERS][DATA_WIDTH]  per-master write data.
- OTM_PREADY  out  [NO_OF_MASTERS]  per-master completion.
- OTM_PRDATA  out  [NO_OF_MASTERS][DATA_WIDTH]  per-master read data.
- OTM_PSLVERR  out  [NO_OF_MASTERS]  per-master error.
- OTS_PSEL  out  [NO_OF_SLAVES]  one-hot slave select.
- OTS_PENABLE  out  1  shared enable to slaves.
- OTS_PWRITE  out  1  shared direction to slaves.
- OTS_PADDR  out  ADDR_WIDTH  shared address to slaves.
- OTS_PWDATA  out  DATA_WIDTH  shared write data to slaves.
- IFS_PREADY  in  [NO_OF_SLAVES]  per-slave ready.
- IFS_PRDATA  in  [NO_OF_SLAVES][DATA_WIDTH]  per-slave read data.
- IFS_PSLVERR  in  [NO_OF_SLAVES]  per-slave error.
- O_GRANT  out  [NO_OF_MASTERS]  one-hot current grant, for debug and visibility.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer 0, latched address/control 0.
- FSM states: IDLE, SETUP, ACCESS, DECERR.

IDLE:
- If any IFM_PSEL bit is high, arbitrate, register the grant, and latch the winner's PADDR, PWRITE and PWDATA.
- Decode the latched address. If a region hits, go to SETUP. If no region hits, go to DECERR.
- If no request, stay in IDLE.

Arbitration:
- Fixed priority: lowest requesting index wins.
- Round robin: search starts at the pointer and wraps modulo NO_OF_MASTERS.
- After each completed transfer (normal or error), the pointer becomes granted index + 1, wrapping to 0.
- Pointer does not move in IDLE cycles with no request.

Decode:
- Overlapping regions resolve to the lowest slave index.
- Address comparison is unsigned at ADDR_WIDTH. The base+size sum is computed at ADDR_WIDTH+1 bits, so a region ending at 2^ADDR_WIDTH does not wrap.

SETUP (exactly 1 cycle):
- OTS_PSEL[dec]=1, OTS_PENABLE=0.
- Latched address and control driven on the OTS_* buses.
- Next state is ACCESS.

ACCESS:
- OTS_PSEL[dec]=1, OTS_PENABLE=1.
- OTM_PREADY[g] = IFS_PREADY[dec], combinationally.
- OTM_PRDATA[g] and OTM_PSLVERR[g] are passed through combinationally from the decoded slave while IFS_PREADY[dec] is high, otherwise 0.
- When IFS_PREADY[dec]=1, return to IDLE. Otherwise hold, with unlimited wait states.

DECERR (1 cycle):
- No OTS_PSEL asserted.
- OTM_PREADY[g]=1, OTM_PSLVERR[g]=1, OTM_PRDATA[g]=0.
- Next state is IDLE.

Latency and isolation:
- Request sampled in IDLE at cycle T. SETUP at T+1, ACCESS at T+2. A zero-wait slave gives OTM_PREADY[g] at T+2.
- One IDLE turnaround cycle always follows each transfer, so back-to-back transfers complete at best every 3 cycles.
- Non-granted masters see OTM_PREADY, OTM_PRDATA and OTM_PSLVERR all 0 and simply wait. Requests are never dropped.

Protocol corner cases:
- If the granted master drops IFM_PSEL mid-transfer, the slave transfer still completes from latched values; the response is driven but may be ignored.
- A new request from the same master is arbitrated normally in the next IDLE.
- OTS_PADDR, OTS_PWRITE and OTS_PWDATA hold the last latched values while in IDLE. OTS_PSEL and OTS_PENABLE are 0 in IDLE.
- Asynchronous reset mid-transfer returns to IDLE immediately and all outputs go to 0.

Optional Feature:
- Macro: APB_IC_TIMEOUT_EN.
- Defined: a counter clears on entry to ACCESS and increments each ACCESS cycle with IFS_PREADY[dec]=0.
  - When the count reaches TIMEOUT_CYCLES, the interconnect drops OTS_PSEL and OTS_PENABLE in that cycle.
  - In the same cycle it drives OTM_PREADY[g]=1, OTM_PSLVERR[g]=1, OTM_PRDATA[g]=0, then returns to IDLE.
  - The round-robin pointer advances as for a normal completion.
- Not defined: no counter exists, and ACCESS waits indefinitely.

Test Plan:
- Single transfer, 1 master, 4 slaves, write 0xA5A5A5A5 to 0x1004 -> OTS_PSEL=4'b0010 at T+1; OTS_PENABLE=1 at T+2; zero-wait slave gives OTM_PREADY[0]=1 at T+2 with PSLVERR=0.
- Unmapped read of 0x8000 -> no OTS_PSEL ever asserted; OTM_PREADY=1, PSLVERR=1, PRDATA=0 at T+1.
- Round robin, masters 0 and 1 requesting continuously -> grants alternate 0,1,0,1. Under fixed priority (ARBITRATION_TYPE=0), master 0 is always granted.
- Slave 2 inserts 5 wait states -> OTS_PSEL and PENABLE held for 6 ACCESS cycles; master 1 stays waiting with OTM_PREADY[1]=0 until master 0 completes.
- Reset asserted during ACCESS -> all outputs 0 at once; after release, the first request gets SETUP one cycle after it is sampled; round-robin pointer is 0.
- With APB_IC_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never ready -> PSLVERR=1 on the 17th ACCESS cycle, when the counter reaches 16; the bus then returns to IDLE.

Source files
------------

// File: rtl/apb_addr_decode_interconnect.sv
// N-master / M-slave APB interconnect: arbitrates masters, decodes the address to a slave, answers unmapped addresses with PSLVERR.
// Optional ACCESS watchdog enabled by defining APB_IC_TIMEOUT_EN.
module apb_addr_decode_interconnect #(
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int NO_OF_MASTERS    = 2,
    parameter int NO_OF_SLAVES     = 4,
    parameter int ARBITRATION_TYPE = 0,
    parameter logic [ADDR_WIDTH-1:0] SLAVE_BASEADDR [NO_OF_SLAVES] =
        '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000},
    parameter logic [ADDR_WIDTH:0]   SLAVE_SIZE [NO_OF_SLAVES] =
        '{33'h1000, 33'h1000, 33'h1000, 33'h1000},
    parameter int TIMEOUT_CYCLES   = 16
) (
    input  logic                                     I_PCLK,
    input  logic                                     I_PRESETN,
    input  logic [NO_OF_MASTERS-1:0]                 IFM_PSEL,
    input  logic [NO_OF_MASTERS-1:0]                 IFM_PENABLE,
    input  logic [NO_OF_MASTERS-1:0]                 IFM_PWRITE,
    input  logic [NO_OF_MASTERS-1:0][ADDR_WIDTH-1:0] IFM_PADDR,
    input  logic [NO_OF_MASTERS-1:0][DATA_WIDTH-1:0] IFM_PWDATA,
    output logic [NO_OF_MASTERS-1:0]                 OTM_PREADY,
    output logic [NO_OF_MASTERS-1:0][DATA_WIDTH-1:0] OTM_PRDATA,
    output logic [NO_OF_MASTERS-1:0]                 OTM_PSLVERR,
    output logic [NO_OF_SLAVES-1:0]                  OTS_PSEL,
    output logic                                     OTS_PENABLE,
    output logic                                     OTS_PWRITE,
    output logic [ADDR_WIDTH-1:0]                    OTS_PADDR,
    output logic [DATA_WIDTH-1:0]                    OTS_PWDATA,
    input  logic [NO_OF_SLAVES-1:0]                  IFS_PREADY,
    input  logic [NO_OF_SLAVES-1:0][DATA_WIDTH-1:0]  IFS_PRDATA,
    input  logic [NO_OF_SLAVES-1:0]                  IFS_PSLVERR,
    output logic [NO_OF_MASTERS-1:0]                 O_GRANT
);

    localparam int MW = (NO_OF_MASTERS > 1) ? $clog2(NO_OF_MASTERS) : 1;
    localparam int SW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DECERR} state_t;

    state_t                  state;
    logic [MW-1:0]           grant_idx;
    logic [NO_OF_MASTERS-1:0] grant_oh;
    logic [SW-1:0]           dec_idx;
    logic [MW-1:0]           rr_ptr;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    arb_found;
    logic [MW-1:0]           arb_idx;
    logic [MW-1:0]           start_ptr;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic                    dec_hit;
    logic [SW-1:0]           dec_sel;
    logic                    slave_ready;
    logic                    timeout;
    logic [MW-1:0]           ptr_next;
    logic                    penable_unused;

    // Masters' PENABLE carries no routing information; the FSM sequences the slave side itself.
    assign penable_unused = ^IFM_PENABLE;

    assign start_ptr   = (ARBITRATION_TYPE == 1) ? rr_ptr : '0;
    assign slave_ready = IFS_PREADY[dec_idx];
    assign ptr_next    = (grant_idx == MW'(NO_OF_MASTERS - 1)) ? '0 : grant_idx + 1'b1;
    assign win_addr    = IFM_PADDR[arb_idx];

    // Circular search from start_ptr; fixed priority is the special case start_ptr == 0.
    always_comb begin
        logic [MW:0] cand;
        arb_found = 1'b0;
        arb_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NO_OF_MASTERS; i++) begin
            cand = {1'b0, start_ptr} + (MW+1)'(i);
            if (cand >= (MW+1)'(NO_OF_MASTERS)) begin
                cand = cand - (MW+1)'(NO_OF_MASTERS);
            end
            if (!arb_found && IFM_PSEL[cand[MW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = cand[MW-1:0];
            end
        end
    end

    // Scanning downwards lets the lowest overlapping slave index win; the +1 bit keeps a region ending at 2^ADDR_WIDTH from wrapping.
    always_comb begin
        dec_hit = 1'b0;
        dec_sel = '0;
        for (int s = NO_OF_SLAVES - 1; s >= 0; s--) begin
            if (({1'b0, win_addr} >= {1'b0, SLAVE_BASEADDR[s]}) &&
                ({1'b0, win_addr} <  ({1'b0, SLAVE_BASEADDR[s]} + SLAVE_SIZE[s]))) begin
                dec_hit = 1'b1;
                dec_sel = SW'(s);
            end
        end
    end

`ifdef APB_IC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;

    assign timeout = (state == ACCESS) && (to_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
        if (!I_PRESETN) begin
            to_cnt <= '0;
        end else if (state == SETUP) begin
            to_cnt <= '0;
        end else if ((state == ACCESS) && !slave_ready && !timeout) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge I_PCLK or negedge I_PRESETN) begin
        if (!I_PRESETN) begin
            state     <= IDLE;
            grant_idx <= '0;
            grant_oh  <= '0;
            dec_idx   <= '0;
            rr_ptr    <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found) begin
                        grant_idx <= arb_idx;
                        grant_oh  <= NO_OF_MASTERS'(1) << arb_idx;
                        addr_q    <= IFM_PADDR[arb_idx];
                        write_q   <= IFM_PWRITE[arb_idx];
                        wdata_q   <= IFM_PWDATA[arb_idx];
                        dec_idx   <= dec_sel;
                        state     <= dec_hit ? SETUP : DECERR;
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (slave_ready || timeout) begin
                        state    <= IDLE;
                        grant_oh <= '0;
                        rr_ptr   <= ptr_next;
                    end
                end
                DECERR: begin
                    state    <= IDLE;
                    grant_oh <= '0;
                    rr_ptr   <= ptr_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response path is combinational so a zero-wait slave completes in the first ACCESS cycle.
    always_comb begin
        OTS_PSEL    = '0;
        OTS_PENABLE = 1'b0;
        OTM_PREADY  = '0;
        OTM_PRDATA  = '0;
        OTM_PSLVERR = '0;
        case (state)
            SETUP: begin
                OTS_PSEL[dec_idx] = 1'b1;
            end
            ACCESS: begin
                if (timeout) begin
                    OTM_PREADY[grant_idx]  = 1'b1;
                    OTM_PSLVERR[grant_idx] = 1'b1;
                end else begin
                    OTS_PSEL[dec_idx]     = 1'b1;
                    OTS_PENABLE           = 1'b1;
                    OTM_PREADY[grant_idx] = slave_ready;
                    if (slave_ready) begin
                        OTM_PRDATA[grant_idx]  = IFS_PRDATA[dec_idx];
                        OTM_PSLVERR[grant_idx] = IFS_PSLVERR[dec_idx];
                    end
                end
            end
            DECERR: begin
                OTM_PREADY[grant_idx]  = 1'b1;
                OTM_PSLVERR[grant_idx] = 1'b1;
            end
            default: ;
        endcase
    end

    assign OTS_PADDR  = addr_q;
    assign OTS_PWRITE = write_q;
    assign OTS_PWDATA = wdata_q;
    assign O_GRANT    = grant_oh;

endmodule

// File: tb/tb_apb_addr_decode_interconnect.sv
// Directed bench for apb_addr_decode_interconnect: a round-robin instance with a wait-state slave model,
// plus a fixed-priority instance with always-ready slaves for the arbitration comparison.
module tb_apb_addr_decode_interconnect;

    logic clk = 1'b0;
    logic rst_n;
    logic rst_fp_n;

    logic [1:0]       m_psel, m_penable, m_pwrite;
    logic [1:0][31:0] m_paddr, m_pwdata;

    logic [1:0]       otm_pready, otm_pslverr;
    logic [1:0][31:0] otm_prdata;
    logic [3:0]       ots_psel;
    logic             ots_penable, ots_pwrite;
    logic [31:0]      ots_paddr, ots_pwdata;
    logic [3:0]       ifs_pready, ifs_pslverr;
    logic [3:0][31:0] ifs_prdata;
    logic [1:0]       o_grant;

    logic [1:0]       fp_pready, fp_pslverr;
    logic [1:0][31:0] fp_prdata;
    logic [3:0]       fp_psel;
    logic             fp_penable, fp_pwrite;
    logic [31:0]      fp_paddr, fp_pwdata;
    logic [1:0]       fp_grant;
    logic [3:0]       fp_ifs_pready  = 4'hF;
    logic [3:0]       fp_ifs_pslverr = 4'h0;
    logic [3:0][31:0] fp_ifs_prdata  = '0;

    logic [7:0] wcnt;
    logic [7:0] wait_cfg;
    logic [3:0] err_cfg;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    apb_addr_decode_interconnect #(.ARBITRATION_TYPE(1)) dut (
        .I_PCLK(clk), .I_PRESETN(rst_n),
        .IFM_PSEL(m_psel), .IFM_PENABLE(m_penable), .IFM_PWRITE(m_pwrite),
        .IFM_PADDR(m_paddr), .IFM_PWDATA(m_pwdata),
        .OTM_PREADY(otm_pready), .OTM_PRDATA(otm_prdata), .OTM_PSLVERR(otm_pslverr),
        .OTS_PSEL(ots_psel), .OTS_PENABLE(ots_penable), .OTS_PWRITE(ots_pwrite),
        .OTS_PADDR(ots_paddr), .OTS_PWDATA(ots_pwdata),
        .IFS_PREADY(ifs_pready), .IFS_PRDATA(ifs_prdata), .IFS_PSLVERR(ifs_pslverr),
        .O_GRANT(o_grant)
    );

    apb_addr_decode_interconnect #(.ARBITRATION_TYPE(0)) dut_fp (
        .I_PCLK(clk), .I_PRESETN(rst_fp_n),
        .IFM_PSEL(m_psel), .IFM_PENABLE(m_penable), .IFM_PWRITE(m_pwrite),
        .IFM_PADDR(m_paddr), .IFM_PWDATA(m_pwdata),
        .OTM_PREADY(fp_pready), .OTM_PRDATA(fp_prdata), .OTM_PSLVERR(fp_pslverr),
        .OTS_PSEL(fp_psel), .OTS_PENABLE(fp_penable), .OTS_PWRITE(fp_pwrite),
        .OTS_PADDR(fp_paddr), .OTS_PWDATA(fp_pwdata),
        .IFS_PREADY(fp_ifs_pready), .IFS_PRDATA(fp_ifs_prdata), .IFS_PSLVERR(fp_ifs_pslverr),
        .O_GRANT(fp_grant)
    );

    function automatic logic [31:0] slave_data(input int s);
        return {16'hC0DE, s[7:0], 8'h5A};
    endfunction

    // Slave model: the selected slave becomes ready after wait_cfg ACCESS cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= '0;
        else if (ots_penable && (|ots_psel)) wcnt <= (wcnt == wait_cfg) ? 8'd0 : wcnt + 8'd1;
        else wcnt <= '0;
    end

    assign ifs_pready  = (ots_penable && (wcnt == wait_cfg)) ? ots_psel : 4'b0000;
    assign ifs_pslverr = err_cfg;
    always_comb begin
        for (int s = 0; s < 4; s++) ifs_prdata[s] = slave_data(s);
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_idle(input logic [31:0] addr);
        check_output("idle_psel", 32'(ots_psel), 32'h0);
        check_output("idle_penable", 32'(ots_penable), 32'h0);
        check_output("idle_pready", 32'(otm_pready), 32'h0);
        check_output("idle_grant", 32'(o_grant), 32'h0);
        check_output("idle_paddr_hold", ots_paddr, addr);
    endtask

    // Called at a negedge with the interconnect idle; returns at the negedge of the following IDLE cycle.
    task automatic apply_stimulus(input int m, input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input int waits, input int slv,
                                  input logic err);
        logic [1:0] mbit;
        mbit = 2'b01 << m;
        wait_cfg = 8'(waits);
        err_cfg  = (slv >= 0 && err) ? 4'hF : 4'h0;
        m_psel = mbit; m_penable = 2'b00;
        m_pwrite[m] = wr; m_paddr[m] = addr; m_pwdata[m] = wdata;
        @(negedge clk);
        check_output("txn_grant", 32'(o_grant), 32'(mbit));
        if (slv >= 0) begin
            check_output("setup_psel", 32'(ots_psel), 32'h1 << slv);
            check_output("setup_penable", 32'(ots_penable), 32'h0);
            check_output("setup_paddr", ots_paddr, addr);
            check_output("setup_pwrite", 32'(ots_pwrite), 32'(wr));
            check_output("setup_pwdata", ots_pwdata, wdata);
            check_output("setup_pready", 32'(otm_pready), 32'h0);
            m_penable = mbit;
            for (int k = 0; k <= waits; k++) begin
                @(negedge clk);
                check_output("access_psel", 32'(ots_psel), 32'h1 << slv);
                check_output("access_penable", 32'(ots_penable), 32'h1);
                if (k < waits) begin
                    check_output("access_wait_pready", 32'(otm_pready), 32'h0);
                end else begin
                    check_output("access_pready", 32'(otm_pready), 32'(mbit));
                    check_output("access_prdata", otm_prdata[m], slave_data(slv));
                    check_output("access_pslverr", 32'(otm_pslverr), err ? 32'(mbit) : 32'h0);
                end
            end
        end else begin
            check_output("decerr_psel", 32'(ots_psel), 32'h0);
            check_output("decerr_pready", 32'(otm_pready), 32'(mbit));
            check_output("decerr_pslverr", 32'(otm_pslverr), 32'(mbit));
            check_output("decerr_prdata", otm_prdata[m], 32'h0);
        end
        m_psel = 2'b00; m_penable = 2'b00;
        @(negedge clk);
        check_idle(addr);
    endtask

    typedef struct {
        int          m;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        int          slv;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 0,  1, 1'b0};
        vecs[1] = '{1, 1'b0, 32'h0000_0000, 32'h0000_0000, 0,  0, 1'b0};
        vecs[2] = '{0, 1'b0, 32'h0000_3FFC, 32'h0000_0000, 2,  3, 1'b0};
        vecs[3] = '{1, 1'b1, 32'h0000_2000, 32'h5555_AAAA, 5,  2, 1'b1};
        vecs[4] = '{0, 1'b0, 32'h0000_8000, 32'h0000_0000, 0, -1, 1'b1};
        vecs[5] = '{1, 1'b1, 32'h0000_4000, 32'h1234_5678, 0, -1, 1'b1};
        vecs[6] = '{0, 1'b0, 32'h0000_0FFF, 32'h0000_0000, 1,  0, 1'b0};
        vecs[7] = '{1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 0, -1, 1'b1};

        rst_n = 1'b0; rst_fp_n = 1'b0;
        m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
        wait_cfg = 8'd0; err_cfg = 4'h0;
        repeat (3) @(negedge clk);
        check_output("reset_psel", 32'(ots_psel), 32'h0);
        check_output("reset_penable", 32'(ots_penable), 32'h0);
        check_output("reset_paddr", ots_paddr, 32'h0);
        check_output("reset_pwdata", ots_pwdata, 32'h0);
        check_output("reset_pready", 32'(otm_pready), 32'h0);
        check_output("reset_grant", 32'(o_grant), 32'h0);
        rst_n = 1'b1; rst_fp_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            apply_stimulus(vecs[v].m, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                           vecs[v].waits, vecs[v].slv, vecs[v].err);
        end

        // Contention: both masters request continuously; RR alternates, fixed priority keeps master 0.
        rst_fp_n = 1'b0;
        @(negedge clk);
        rst_fp_n = 1'b1;
        wait_cfg = 8'd0; err_cfg = 4'h0;
        m_psel = 2'b11;
        m_pwrite = 2'b01; m_paddr[0] = 32'h1000; m_paddr[1] = 32'h2000;
        m_pwdata[0] = 32'h0BAD_F00D; m_pwdata[1] = 32'h0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("rr_grant", 32'(o_grant), (i % 2 == 0) ? 32'h1 : 32'h2);
            check_output("rr_psel", 32'(ots_psel), (i % 2 == 0) ? 32'h2 : 32'h4);
            check_output("fp_grant", 32'(fp_grant), 32'h1);
            @(negedge clk);
            check_output("rr_pready", 32'(otm_pready), (i % 2 == 0) ? 32'h1 : 32'h2);
            check_output("fp_pready", 32'(fp_pready), 32'h1);
            if (i == 3) m_psel = 2'b00;
            @(negedge clk);
            check_output("rr_turnaround_psel", 32'(ots_psel), 32'h0);
        end

        // Slave 2 with 5 wait states while master 1 waits its turn.
        wait_cfg = 8'd5;
        m_psel = 2'b11;
        m_pwrite = 2'b10; m_paddr[0] = 32'h2000; m_paddr[1] = 32'h1000; m_pwdata[1] = 32'hCAFE_0001;
        @(negedge clk);
        check_output("ws_grant0", 32'(o_grant), 32'h1);
        check_output("ws_psel0", 32'(ots_psel), 32'h4);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_output("ws_access_psel", 32'(ots_psel), 32'h4);
            check_output("ws_access_penable", 32'(ots_penable), 32'h1);
            check_output("ws_pready", 32'(otm_pready), (k == 5) ? 32'h1 : 32'h0);
        end
        m_psel[0] = 1'b0;
        @(negedge clk);
        check_output("ws_idle_pready", 32'(otm_pready), 32'h0);
        @(negedge clk);
        check_output("ws_grant1", 32'(o_grant), 32'h2);
        check_output("ws_psel1", 32'(ots_psel), 32'h2);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_output("ws_m1_pready", 32'(otm_pready), (k == 5) ? 32'h2 : 32'h0);
        end
        m_psel = 2'b00;
        @(negedge clk);

        // Move the RR pointer to 1, then reset mid-ACCESS and confirm it returns to 0.
        apply_stimulus(0, 1'b0, 32'h3000, 32'h0, 0, 3, 1'b0);
        wait_cfg = 8'd5;
        m_psel = 2'b10; m_pwrite[1] = 1'b1; m_paddr[1] = 32'h1008; m_pwdata[1] = 32'h1234_5678;
        @(negedge clk);
        @(negedge clk);
        check_output("pre_reset_penable", 32'(ots_penable), 32'h1);
        rst_n = 1'b0;
        #1;
        check_output("async_reset_psel", 32'(ots_psel), 32'h0);
        check_output("async_reset_penable", 32'(ots_penable), 32'h0);
        check_output("async_reset_paddr", ots_paddr, 32'h0);
        check_output("async_reset_pwdata", ots_pwdata, 32'h0);
        check_output("async_reset_pwrite", 32'(ots_pwrite), 32'h0);
        check_output("async_reset_grant", 32'(o_grant), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_cfg = 8'd0;
        m_psel = 2'b11; m_pwrite = 2'b00; m_paddr[0] = 32'h0010;
        @(negedge clk);
        check_output("post_reset_grant", 32'(o_grant), 32'h1);
        check_output("post_reset_psel", 32'(ots_psel), 32'h1);
        check_output("post_reset_penable", 32'(ots_penable), 32'h0);
        @(negedge clk);
        check_output("post_reset_pready", 32'(otm_pready), 32'h1);
        m_psel = 2'b00;
        @(negedge clk);

        // Slave that stalls for 20 cycles: times out on the 17th ACCESS cycle only with the watchdog built in.
        wait_cfg = 8'd20;
        m_psel = 2'b01; m_paddr[0] = 32'h1000; m_pwrite[0] = 1'b0;
        @(negedge clk);
        check_output("long_setup_psel", 32'(ots_psel), 32'h2);
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
`ifdef APB_IC_TIMEOUT_EN
            if (k == 16) begin
                check_output("timeout_pready", 32'(otm_pready), 32'h1);
                check_output("timeout_pslverr", 32'(otm_pslverr), 32'h1);
                check_output("timeout_prdata", otm_prdata[0], 32'h0);
                check_output("timeout_psel", 32'(ots_psel), 32'h0);
                check_output("timeout_penable", 32'(ots_penable), 32'h0);
                break;
            end
`endif
            check_output("long_wait_psel", 32'(ots_psel), 32'h2);
            check_output("long_wait_pready", 32'(otm_pready), (k == 20) ? 32'h1 : 32'h0);
        end
        m_psel = 2'b00;
        @(negedge clk);
        check_output("long_end_psel", 32'(ots_psel), 32'h0);
        check_output("long_end_pready", 32'(otm_pready), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
